// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver control states and line-edge helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        RECEIVE   = 3'd2,
        STOP_CHK  = 3'd3,
        LOAD      = 3'd4,
        FRAME_ERR = 3'd5
    } rx_state_t;

    function automatic logic is_fall(input logic line, input logic line_prev);
        return (line == 1'b0) && (line_prev == 1'b1);
    endfunction

endpackage

// File: rtl/sync_high.sv
// Two-flop synchronizer for an idle-high line; both stages reset to 1.
module sync_high (
    input  logic clk,
    input  logic n_rst,
    input  logic async_i,
    output logic sync_o
);
    logic meta_q;
    logic sync_q;

    // Metastability filter stages
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;
endmodule

// File: rtl/rcu_controller.sv
// UART receiver control unit: sequences the bit timer and RX buffer load for
// one frame and keeps the sticky data-ready / framing / overrun flags.
module rcu_controller
    import uart_pkg::*;
#(
    parameter int SYNC_EN = 1
) (
    input  logic clk,
    input  logic n_rst,
    input  logic serial_in,
    input  logic packet_done,
    input  logic stop_bit,
    input  logic data_read,
    output logic enable_timer,
    output logic timer_clear,
    output logic load_buffer,
    output logic data_ready,
    output logic framing_error,
    output logic overrun_error,
    output logic rx_busy
);
    localparam logic [1:0] FILL_DEPTH = (SYNC_EN != 0) ? 2'd2 : 2'd0;

    rx_state_t  state_q, state_d;
    logic       line_s, start_s, fill_done_s;
    logic       prev_q;
    logic       armed_q, armed_d;
    logic [1:0] fill_q, fill_d;
    logic       ready_q, ready_d, frame_err_q, frame_err_d, overrun_q, overrun_d;
    logic       en_timer_q, en_timer_d, clr_q, clr_d, load_q, load_d, busy_q, busy_d;

    generate
        if (SYNC_EN != 0) begin : g_sync
            sync_high u_sync (
                .clk    (clk),
                .n_rst  (n_rst),
                .async_i(serial_in),
                .sync_o (line_s)
            );
        end else begin : g_direct
            assign line_s = serial_in;
        end
    endgenerate

    // Reset values make the line look high; only a genuinely observed high arms start detection.
    assign fill_done_s = (fill_q == FILL_DEPTH);
    assign start_s     = armed_q && is_fall(line_s, prev_q);

    // Synchronizer fill tracking and start-detect arming
    always_comb begin
        fill_d  = fill_q;
        armed_d = armed_q;
        if (!fill_done_s) begin
            fill_d = fill_q + 2'd1;
        end else begin
            fill_d = fill_q;
        end
        if (fill_done_s && line_s) begin
            armed_d = 1'b1;
        end else begin
            armed_d = armed_q;
        end
    end

    // Frame sequencing next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (start_s) state_d = START; else state_d = IDLE;
            START:     state_d = RECEIVE;
            RECEIVE:   if (packet_done) state_d = STOP_CHK; else state_d = RECEIVE;
            STOP_CHK:  if (stop_bit) state_d = LOAD; else state_d = FRAME_ERR;
            LOAD:      state_d = IDLE;
            FRAME_ERR: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Sticky flags and registered output strobes
    always_comb begin
        ready_d     = ready_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        if (state_q == LOAD) begin
            ready_d   = 1'b1;
            overrun_d = overrun_q | (ready_q & ~data_read);
        end else if (data_read) begin
            ready_d   = 1'b0;
            overrun_d = 1'b0;
        end else begin
            ready_d   = ready_q;
            overrun_d = overrun_q;
        end
        if ((state_q == STOP_CHK) && !stop_bit) begin
            frame_err_d = 1'b1;
        end else if (state_d == START) begin
            frame_err_d = 1'b0;
        end else begin
            frame_err_d = frame_err_q;
        end
        en_timer_d = (state_d == RECEIVE);
        clr_d      = (state_d == START);
        load_d     = (state_d == LOAD);
        busy_d     = (state_d != IDLE);
    end

    // State, edge-detect and output registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            prev_q      <= 1'b1;
            armed_q     <= 1'b0;
            fill_q      <= 2'd0;
            ready_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            en_timer_q  <= 1'b0;
            clr_q       <= 1'b0;
            load_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= line_s;
            armed_q     <= armed_d;
            fill_q      <= fill_d;
            ready_q     <= ready_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            en_timer_q  <= en_timer_d;
            clr_q       <= clr_d;
            load_q      <= load_d;
            busy_q      <= busy_d;
        end
    end

    assign enable_timer  = en_timer_q;
    assign timer_clear   = clr_q;
    assign load_buffer   = load_q;
    assign data_ready    = ready_q;
    assign framing_error = frame_err_q;
    assign overrun_error = overrun_q;
    assign rx_busy       = busy_q;
endmodule

// File: tb/tb_rcu_controller.sv
// Randomized bench for rcu_controller: one instance with and one without the
// input synchronizer, both checked every cycle against a frame-level model.
module tb_rcu_controller;
    logic clk, n_rst, serial_in, packet_done, stop_bit, data_read;
    logic et0, tc0, lb0, dr0, fe0, ov0, bz0;
    logic et1, tc1, lb1, dr1, fe1, ov1, bz1;

    int n_checks = 0;
    int n_errors = 0;
    bit rnd_read = 1'b0;
    bit lb_seen  = 1'b0;

    // Model: raw line samples since reset, frame phase and flags per instance
    bit raw_q[$];
    int stage [2];
    bit m_dr  [2];
    bit m_fe  [2];
    bit m_ov  [2];

    rcu_controller #(.SYNC_EN(0)) dut0 (
        .clk(clk), .n_rst(n_rst), .serial_in(serial_in), .packet_done(packet_done),
        .stop_bit(stop_bit), .data_read(data_read), .enable_timer(et0), .timer_clear(tc0),
        .load_buffer(lb0), .data_ready(dr0), .framing_error(fe0), .overrun_error(ov0),
        .rx_busy(bz0)
    );

    rcu_controller #(.SYNC_EN(1)) dut1 (
        .clk(clk), .n_rst(n_rst), .serial_in(serial_in), .packet_done(packet_done),
        .stop_bit(stop_bit), .data_read(data_read), .enable_timer(et1), .timer_clear(tc1),
        .load_buffer(lb1), .data_ready(dr1), .framing_error(fe1), .overrun_error(ov1),
        .rx_busy(bz1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] dut_vec(input int k);
        if (k == 0) return {1'b0, et0, tc0, lb0, dr0, fe0, ov0, bz0};
        else        return {1'b0, et1, tc1, lb1, dr1, fe1, ov1, bz1};
    endfunction

    function automatic logic [7:0] exp_vec(input int k);
        return {1'b0, stage[k] == 2, stage[k] == 1, stage[k] == 4,
                m_dr[k], m_fe[k], m_ov[k], stage[k] != 0};
    endfunction

    task automatic model_reset();
        raw_q.delete();
        for (int k = 0; k < 2; k++) begin
            stage[k] = 0;
            m_dr[k]  = 1'b0;
            m_fe[k]  = 1'b0;
            m_ov[k]  = 1'b0;
        end
    endtask

    // A start is a high-to-low step between two post-reset samples, seen d edges late.
    task automatic model_step();
        int e, d, s;
        bit fell;
        raw_q.push_back(serial_in);
        e = raw_q.size();
        for (int k = 0; k < 2; k++) begin
            d = (k == 1) ? 2 : 0;
            fell = 1'b0;
            if (e - d - 1 >= 1)
                fell = (raw_q[e-d-1] == 1'b0) && (raw_q[e-d-2] == 1'b1);
            s = stage[k];
            if (s == 4) begin
                m_ov[k] = m_ov[k] | (m_dr[k] & ~data_read);
                m_dr[k] = 1'b1;
            end else if (data_read) begin
                m_dr[k] = 1'b0;
                m_ov[k] = 1'b0;
            end
            case (s)
                0: if (fell) begin stage[k] = 1; m_fe[k] = 1'b0; end
                1: stage[k] = 2;
                2: if (packet_done) stage[k] = 3;
                3: if (stop_bit) stage[k] = 4; else begin stage[k] = 5; m_fe[k] = 1'b1; end
                default: stage[k] = 0;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (n_rst) model_step(); else model_reset();
        #1;
        check_val("cycle_dut0", dut_vec(0), exp_vec(0));
        check_val("cycle_dut1", dut_vec(1), exp_vec(1));
        if (lb0 || lb1) lb_seen = 1'b1;
    endtask

    task automatic cyc();
        if (rnd_read) data_read = ($urandom_range(0, 7) == 0);
        tick();
    endtask

    task automatic frame(input int b, input bit good, input bit collide,
                         input bit lat_chk, input bit fe_before);
        lb_seen   = 1'b0;
        stop_bit  = good;
        serial_in = 1'b0;
        for (int c = 0; c < b; c++) begin
            cyc();
            if (lat_chk && c == 0) begin
                check_val("lat_nosync_busy", {7'd0, bz0}, 8'd1);
                check_val("lat_sync_e1", {7'd0, bz1}, 8'd0);
            end
            if (lat_chk && c == 1) begin
                check_val("lat_sync_e2", {7'd0, bz1}, 8'd0);
                check_val("fe_before_start", {7'd0, fe1}, {7'd0, fe_before});
            end
            if (lat_chk && c == 2) begin
                check_val("lat_sync_e3", {7'd0, bz1}, 8'd1);
                check_val("fe_clear_at_start", {7'd0, fe1}, 8'd0);
                check_val("timer_clear_start", {7'd0, tc1}, 8'd1);
            end
        end
        for (int i = 0; i < 8; i++) begin
            serial_in = 1'($urandom_range(0, 1));
            repeat (b) cyc();
        end
        serial_in = good;
        repeat (b - 1) cyc();
        packet_done = 1'b1;
        cyc();
        packet_done = 1'b0;
        serial_in   = 1'b1;
        cyc();
        if (collide) begin
            data_read = 1'b1;
            tick();
            data_read = 1'b0;
        end else begin
            cyc();
        end
        data_read = 1'b0;
    endtask

    task automatic gap(input int n, input bit pd_noise);
        for (int i = 0; i < n; i++) begin
            packet_done = pd_noise && ($urandom_range(0, 3) == 0);
            cyc();
        end
        packet_done = 1'b0;
        data_read   = 1'b0;
    endtask

    task automatic flags_chk(input string tag, input logic [2:0] exp);
        check_val({tag, "_nosync"}, {5'd0, dr0, fe0, ov0}, {5'd0, exp});
        check_val({tag, "_sync"},   {5'd0, dr1, fe1, ov1}, {5'd0, exp});
    endtask

    initial begin
        n_rst = 1'b0; serial_in = 1'b1; packet_done = 1'b0; stop_bit = 1'b1; data_read = 1'b0;
        model_reset();
        #12;
        check_val("reset_nosync", dut_vec(0), 8'd0);
        check_val("reset_sync",   dut_vec(1), 8'd0);
        n_rst = 1'b1;
        repeat (6) cyc();

        frame(4, 1'b1, 1'b0, 1'b1, 1'b0); gap(3, 1'b0);
        flags_chk("good_frame", 3'b100);
        frame(5, 1'b1, 1'b0, 1'b0, 1'b0); gap(3, 1'b0);
        flags_chk("overrun", 3'b101);
        data_read = 1'b1; cyc(); data_read = 1'b0;
        flags_chk("read_clears", 3'b000);
        frame(4, 1'b1, 1'b0, 1'b0, 1'b0); gap(3, 1'b0);
        frame(6, 1'b1, 1'b1, 1'b0, 1'b0); gap(3, 1'b0);
        flags_chk("collision", 3'b100);
        frame(4, 1'b0, 1'b0, 1'b0, 1'b0); gap(3, 1'b0);
        flags_chk("bad_stop", 3'b110);
        check_val("bad_stop_no_load", {7'd0, lb_seen}, 8'd0);
        frame(5, 1'b1, 1'b0, 1'b1, 1'b1); gap(3, 1'b0);
        flags_chk("after_bad", 3'b101);

        serial_in = 1'b0; stop_bit = 1'b1;
        repeat (6) cyc();
        n_rst = 1'b0;
        #1;
        check_val("rst_async_nosync", dut_vec(0), 8'd0);
        check_val("rst_async_sync",   dut_vec(1), 8'd0);
        model_reset();
        repeat (2) tick();
        n_rst = 1'b1;
        repeat (10) tick();
        check_val("low_line_no_start_nosync", {7'd0, bz0}, 8'd0);
        check_val("low_line_no_start_sync",   {7'd0, bz1}, 8'd0);
        serial_in = 1'b1;
        repeat (3) tick();
        frame(5, 1'b1, 1'b0, 1'b1, 1'b0); gap(4, 1'b0);
        flags_chk("after_reset_frame", 3'b100);

        rnd_read = 1'b1;
        for (int f = 0; f < 30; f++) begin
            frame($urandom_range(4, 8), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) == 0, 1'b0, 1'b0);
            gap($urandom_range(3, 9), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/rcu_controller.md
RCU_CONTROLLER -- requirements
Module: rcu_controller

Interface
REQ-001 SHALL have parameter SYNC_EN, default 1, meaning 1 = internal 2-flop synchronizer on serial_in and 0 = serial_in already synchronous.
REQ-002 SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-003 SHALL have port n_rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port serial_in, input, 1, raw UART line, idle high.
REQ-005 SHALL have port packet_done, input, 1, one-cycle pulse from the bit/packet timer at end of the stop bit.
REQ-006 SHALL have port stop_bit, input, 1, stop-bit value captured by the receive shift register.
REQ-007 SHALL have port data_read, input, 1, consumer acknowledge of the received byte.
REQ-008 SHALL have port enable_timer, output, 1, count enable to the bit/packet timer.
REQ-009 SHALL have port timer_clear, output, 1, synchronous clear to both timer counters.
REQ-010 SHALL have port load_buffer, output, 1, one-cycle strobe to copy the shift register into the RX data buffer.
REQ-011 SHALL have port data_ready, output, 1, sticky flag meaning a byte is available.
REQ-012 SHALL have port framing_error, output, 1, sticky flag meaning the last frame had a bad stop bit.
REQ-013 SHALL have port overrun_error, output, 1, sticky flag meaning an unread byte was overwritten.
REQ-014 SHALL have port rx_busy, output, 1, high whenever the state is not IDLE.

Function
REQ-015 SHALL implement states IDLE, START, RECEIVE, STOP_CHK, LOAD, FRAME_ERR.
REQ-016 SHALL detect a start condition in IDLE when the synchronized line is 0 and its registered previous value is 1 (falling edge), and move to START on the next edge.
REQ-017 SHALL enter START on the 3rd rising edge sampling serial_in low when SYNC_EN=1, and on the 1st such edge when SYNC_EN=0.
REQ-018 SHALL ignore falling edges in every state except IDLE.
REQ-019 SHALL hold START exactly one cycle, asserting timer_clear with enable_timer=0, then move to RECEIVE.
REQ-020 SHALL hold enable_timer=1 throughout RECEIVE and move to STOP_CHK in the cycle after packet_done is sampled high.
REQ-021 SHALL, in STOP_CHK (one cycle, enable_timer=0), move to LOAD if stop_bit=1 and otherwise to FRAME_ERR.
REQ-022 SHALL assert load_buffer only during the single LOAD cycle, then return to IDLE.
REQ-023 SHALL set data_ready at the edge leaving LOAD, and clear it on data_read in any cycle other than LOAD; LOAD wins over a simultaneous data_read.
REQ-024 SHALL set overrun_error at the edge leaving LOAD if data_ready=1 and data_read=0 in that cycle, and clear it on data_read outside LOAD.
REQ-025 SHALL set framing_error at the edge leaving STOP_CHK with stop_bit=0, hold it until the next START entry, and never pulse load_buffer for that frame.
REQ-026 SHALL hold FRAME_ERR one cycle, then return to IDLE.
REQ-027 SHALL drive all outputs from registered state or flags; no combinational path from inputs to outputs.
REQ-028 SHALL treat a packet_done pulse outside RECEIVE as no effect.

Reset
REQ-029 SHALL, on n_rst=0, immediately force state IDLE; enable_timer, timer_clear, load_buffer, data_ready, framing_error, overrun_error and rx_busy to 0; synchronizer and edge-detect registers to 1.
REQ-030 SHALL, on reset asserted mid-frame, leave no residual flags, and the next frame SHALL need a fresh falling edge.

Structure
REQ-031 SHALL define the state enum rx_state_t in shared package uart_pkg, which the other UART blocks also use.
REQ-032 SHALL instantiate one sub-module, sync_high, a 2-flop synchronizer that resets to 1, when SYNC_EN=1.

Verification
REQ-033 SHALL cover a valid frame: serial_in low for 1 bit time, 8 data bits, stop=1 -> timer_clear one cycle, enable_timer high until packet_done, load_buffer one pulse, data_ready=1, framing_error=0.
REQ-034 SHALL cover a bad stop bit: stop_bit=0 at STOP_CHK -> framing_error=1, no load_buffer, data_ready unchanged; the next good frame clears framing_error at START.
REQ-035 SHALL cover overrun: two good frames with no data_read -> overrun_error=1 after the second LOAD; a single data_read clears data_ready and overrun_error.
REQ-036 SHALL cover a collision: data_read=1 during the LOAD cycle with data_ready=1 -> data_ready stays 1 and overrun_error stays 0.
REQ-037 SHALL cover reset during RECEIVE: n_rst pulsed low -> all outputs 0 asynchronously, state IDLE, and line held low after reset does not start a frame until a high-to-low edge.
REQ-038 SHALL cover start latency: with SYNC_EN=1, rx_busy rises exactly 3 edges after serial_in falls; with SYNC_EN=0, exactly 1 edge.
